reg_bus_master: RTL and testbench



---
 rtl/reg_bus_master_pkg.sv | 29 ++
 rtl/reg_cmd_fifo.sv | 69 ++++++
 rtl/reg_bus_master.sv | 227 ++++++++++++++++++++++
 tb/tb_reg_bus_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_master_pkg.sv
// Shared types and sizing for the register-bus command initiator.
package reg_bus_master_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CMD_DEPTH = 4;
    localparam int unsigned PTR_W     = (CMD_DEPTH > 2) ? $clog2(CMD_DEPTH) : 1;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_e;

    typedef struct packed {
        logic              wr;
        logic              poll;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of bus commands with registered flags and head.
module reg_cmd_fifo
    import reg_bus_master_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t din_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_t             mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             dout_q, dout_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d   = (cnt_d == CNT_W'(CMD_DEPTH));
        empty_d  = (cnt_d == '0);
        // A push into an (effectively) empty FIFO becomes the head directly.
        if (push_ok && ((cnt_q - CNT_W'(pop_ok)) == '0)) begin
            dout_d = din_i;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    // full reads high during reset so nothing is accepted until one cycle after release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b1;
            empty_q  <= 1'b1;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = dout_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/reg_bus_master.sv
// Command-driven register-bus initiator: queued commands out as single-cycle accesses, one response each.
// Optional polling reads are enabled by defining REG_BUS_MASTER_POLL_EN.
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned POLL_MAX = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic              cmd_poll_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_wr_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              acc_en_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [DATA_W-1:0] rdata_i
);

    localparam int unsigned WAIT_W    = cnt_w(RD_LAT);
    localparam int unsigned WAIT_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d, fifo_din, fifo_dout, issue_cmd_c;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop_c;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              acc_en_q, acc_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
    logic              issue_c, sample_c, resp_c;

    assign fifo_din  = '{wr: cmd_wr_i, poll: cmd_poll_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    assign fifo_push = cmd_valid_i && !fifo_full;

    reg_cmd_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop_c),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef REG_BUS_MASTER_POLL_EN
    localparam int unsigned ATT_W    = cnt_w(POLL_MAX);
    localparam int unsigned GAP_W    = cnt_w(POLL_GAP);
    localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    logic [ATT_W-1:0] att_q, att_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             rsp_err_q, rsp_err_d, err_c;
`else
    logic unused_poll_c;
    assign unused_poll_c = ^{cmd_q.poll, 32'(POLL_GAP), 32'(POLL_MAX)};
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        wait_d      = wait_q;
        acc_en_d    = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop_c  = 1'b0;
        issue_c     = 1'b0;
        issue_cmd_c = cmd_q;
        sample_c    = 1'b0;
        resp_c      = 1'b0;
`ifdef REG_BUS_MASTER_POLL_EN
        att_d       = att_q;
        gap_d       = gap_q;
        rsp_err_d   = rsp_err_q;
        err_c       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop_c  = 1'b1;
                    cmd_d       = fifo_dout;
                    issue_c     = 1'b1;
                    issue_cmd_c = fifo_dout;
`ifdef REG_BUS_MASTER_POLL_EN
                    att_d       = ATT_W'(1);
`endif
                end
            end
            ISSUE: begin
                if (RD_LAT == 0) begin
                    sample_c = 1'b1;
                end else begin
                    state_d = WAIT;
                    wait_d  = '0;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_W'(WAIT_LAST)) begin
                    sample_c = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_wr_d    = 1'b0;
                    rsp_rdata_d = '0;
`ifdef REG_BUS_MASTER_POLL_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
`ifdef REG_BUS_MASTER_POLL_EN
            GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    issue_c = 1'b1;
                    att_d   = att_q + ATT_W'(1);
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (issue_c) begin
            state_d  = ISSUE;
            acc_en_d = 1'b1;
            wr_en_d  = issue_cmd_c.wr;
            addr_d   = issue_cmd_c.addr;
            wdata_d  = issue_cmd_c.wdata;
        end

        // Read data is only valid at the sample point; a failed poll retries instead of responding.
        if (sample_c) begin
            resp_c = 1'b1;
`ifdef REG_BUS_MASTER_POLL_EN
            if (cmd_q.poll && !cmd_q.wr && ((rdata_i & cmd_q.wdata) == '0)) begin
                if (att_q < ATT_W'(POLL_MAX)) begin
                    resp_c  = 1'b0;
                    state_d = GAP;
                    gap_d   = '0;
                end else begin
                    err_c = 1'b1;
                end
            end
            rsp_err_d = resp_c ? err_c : rsp_err_q;
`endif
            if (resp_c) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_wr_d    = cmd_q.wr;
                rsp_rdata_d = cmd_q.wr ? '0 : rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            wait_q      <= '0;
            acc_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wait_q      <= wait_d;
            acc_en_q    <= acc_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef REG_BUS_MASTER_POLL_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            att_q     <= '0;
            gap_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            att_q     <= att_d;
            gap_q     <= gap_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign cmd_ready_o = !fifo_full;
    assign acc_en_o    = acc_en_q;
    assign wr_en_o     = wr_en_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_wr_o    = rsp_wr_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master (RD_LAT=1, POLL_GAP=2, POLL_MAX=3).
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_wr_i, cmd_poll_i;
    logic [2:0]  cmd_addr_i;
    logic [15:0] cmd_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_wr_o, rsp_err_o;
    logic [15:0] rsp_rdata_o;
    logic        acc_en_o, wr_en_o;
    logic [2:0]  addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rdata_i = 16'h0000;

    always #5 clk = ~clk;

    reg_bus_master #(.RD_LAT(1), .POLL_GAP(2), .POLL_MAX(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_poll_i(cmd_poll_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wr_o(rsp_wr_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .acc_en_o(acc_en_o), .wr_en_o(wr_en_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i)
    );

    typedef struct { logic wr; logic [15:0] rdata; logic err; } rsp_exp_t;
    typedef struct { logic wr; logic [2:0] addr; logic [15:0] wdata; } bus_exp_t;

    rsp_exp_t    sb_q[$];
    bus_exp_t    bus_q[$];
    logic [15:0] rd_vals[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_acc = 0, last_acc_cyc = 0, acc_gap = 0, rsp_rise_cyc = 0;
    logic        prev_v = 1'b0, prev_rdy = 1'b0, prev_wr = 1'b0, prev_err = 1'b0;
    logic [15:0] prev_rd = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: every access must match the next expected access; also plays the register block.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (acc_en_o) begin
                bus_exp_t e;
                n_acc++;
                acc_gap      = cyc - last_acc_cyc;
                last_acc_cyc = cyc;
                check("access_expected", 32'(bus_q.size() > 0), 1);
                if (bus_q.size() > 0) begin
                    e = bus_q.pop_front();
                    check("bus_wr_en", 32'(wr_en_o), 32'(e.wr));
                    check("bus_addr", 32'(addr_o), 32'(e.addr));
                    check("bus_wdata", 32'(wdata_o), 32'(e.wdata));
                end
                if (!wr_en_o) rdata_i = (rd_vals.size() > 0) ? rd_vals.pop_front() : 16'h0000;
            end else if (wr_en_o) begin
                check("wr_en_without_acc", 32'(wr_en_o), 0);
            end
        end
    end

    // Response monitor: in-order scoreboard plus payload stability while stalled.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid_o && !prev_v) rsp_rise_cyc = cyc;
            if (rsp_valid_o && prev_v && !prev_rdy) begin
                check("stall_rdata_stable", 32'(rsp_rdata_o), 32'(prev_rd));
                check("stall_wr_stable", 32'(rsp_wr_o), 32'(prev_wr));
                check("stall_err_stable", 32'(rsp_err_o), 32'(prev_err));
            end
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_exp_t e;
                check("response_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("rsp_wr", 32'(rsp_wr_o), 32'(e.wr));
                    check("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
                    check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                end
            end
            prev_v   = rsp_valid_o;
            prev_rdy = rsp_ready_i;
            prev_rd  = rsp_rdata_o;
            prev_wr  = rsp_wr_o;
            prev_err = rsp_err_o;
        end
    end

    // Offer one command; returns the cycle it was accepted in. Called just after a rising edge.
    task automatic push_cmd(input logic wr, input logic poll, input logic [2:0] addr,
                            input logic [15:0] wd, input int n_bus, input logic exp_rsp,
                            input logic [15:0] exp_rd, input logic exp_err, output int acc_cyc);
        bit ok = 0;
        cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_poll_i = poll;
        cmd_addr_i  = addr; cmd_wdata_i = wd;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin ok = 1; break; end
        end
        check("cmd_accepted", 32'(ok), 1);
        acc_cyc = cyc;
        for (int i = 0; i < n_bus; i++) bus_q.push_back('{wr: wr, addr: addr, wdata: wd});
        if (exp_rsp) sb_q.push_back('{wr: wr, rdata: exp_rd, err: exp_err});
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && bus_q.size() == 0) begin done = 1; break; end
        end
        check("idle_reached", 32'(done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0;
        bit seen;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_poll_i = 1'b0;
        cmd_addr_i = 3'd0; cmd_wdata_i = 16'h0; rsp_ready_i = 1'b1;

        // Reset, then idle
        repeat (3) @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready_o), 0);
        check("rst_acc_en", 32'(acc_en_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_ready", 32'(cmd_ready_o), 1);
        check("idle_bus", 32'({acc_en_o, wr_en_o, addr_o, wdata_o}), 0);
        check("idle_rsp", 32'({rsp_valid_o, rsp_wr_o, rsp_err_o, rsp_rdata_o}), 0);

        // Single write: access at N+2, response at N+4
        a0 = n_acc;
        push_cmd(1'b1, 1'b0, 3'd2, 16'h0155, 1, 1'b1, 16'h0000, 1'b0, n);
        wait_idle();
        check("write_acc_cycle", 32'(last_acc_cyc), 32'(n + 2));
        check("write_rsp_cycle", 32'(rsp_rise_cyc), 32'(n + 4));
        check("write_acc_count", 32'(n_acc - a0), 1);

        // Read held off by backpressure for 5 cycles
        rsp_ready_i = 1'b0;
        a0 = n_acc;
        rd_vals.push_back(16'h03A7);
        push_cmd(1'b0, 1'b0, 3'd5, 16'h0000, 1, 1'b1, 16'h03A7, 1'b0, n);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin seen = 1; break; end
        end
        check("bp_rsp_seen", 32'(seen), 1);
        repeat (5) @(posedge clk); #1;
        check("bp_rdata_held", 32'(rsp_rdata_o), 32'h03A7);
        rsp_ready_i = 1'b1;
        wait_idle();
        check("bp_acc_count", 32'(n_acc - a0), 1);

        // Fill the FIFO behind a stalled command; responses come back in order
        rsp_ready_i = 1'b0;
        a0 = n_acc;
        rd_vals.push_back(16'h1111);
        rd_vals.push_back(16'h3333);
        push_cmd(1'b1, 1'b0, 3'd0, 16'h00A0, 1, 1'b1, 16'h0000, 1'b0, n);
        push_cmd(1'b0, 1'b0, 3'd1, 16'h0000, 1, 1'b1, 16'h1111, 1'b0, n);
        push_cmd(1'b1, 1'b0, 3'd2, 16'h00A2, 1, 1'b1, 16'h0000, 1'b0, n);
        push_cmd(1'b0, 1'b0, 3'd3, 16'h0000, 1, 1'b1, 16'h3333, 1'b0, n);
        push_cmd(1'b1, 1'b0, 3'd4, 16'h00A4, 1, 1'b1, 16'h0000, 1'b0, n);
        @(negedge clk);
        check("full_cmd_ready", 32'(cmd_ready_o), 0);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        wait_idle();
        check("full_acc_count", 32'(n_acc - a0), 5);

        // Reset during WAIT of a read: no response, queued write dropped
        a0 = n_acc;
        rd_vals.push_back(16'hBEEF);
        push_cmd(1'b0, 1'b0, 3'd1, 16'h0000, 1, 1'b0, 16'h0000, 1'b0, n);
        push_cmd(1'b1, 1'b0, 3'd3, 16'h0777, 0, 1'b0, 16'h0000, 1'b0, n);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_en_o) begin seen = 1; break; end
        end
        check("midrst_acc_seen", 32'(seen), 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("midrst_acc_en", 32'(acc_en_o), 0);
        check("midrst_rsp_valid", 32'(rsp_valid_o), 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("midrst_cmd_ready", 32'(cmd_ready_o), 1);
        repeat (10) @(posedge clk); #1;
        check("midrst_acc_count", 32'(n_acc - a0), 1);
        rd_vals.delete();
        rd_vals.push_back(16'h0A5A);
        push_cmd(1'b0, 1'b0, 3'd6, 16'h0000, 1, 1'b1, 16'h0A5A, 1'b0, n);
        wait_idle();
        check("after_rst_acc_cycle", 32'(last_acc_cyc), 32'(n + 2));

`ifdef REG_BUS_MASTER_POLL_EN
        // Poll succeeds on the second attempt
        a0 = n_acc;
        rd_vals.push_back(16'h0000);
        rd_vals.push_back(16'h0003);
        push_cmd(1'b0, 1'b1, 3'd4, 16'h0001, 2, 1'b1, 16'h0003, 1'b0, n);
        wait_idle();
        check("poll_ok_acc_count", 32'(n_acc - a0), 2);
        check("poll_ok_acc_gap", 32'(acc_gap), 4);

        // Poll never matches: three attempts then error
        a0 = n_acc;
        repeat (3) rd_vals.push_back(16'h0002);
        push_cmd(1'b0, 1'b1, 3'd4, 16'h0001, 3, 1'b1, 16'h0002, 1'b1, n);
        wait_idle();
        check("poll_to_acc_count", 32'(n_acc - a0), 3);
        check("poll_to_acc_gap", 32'(acc_gap), 4);
`else
        // Without polling support a poll request is a plain read
        a0 = n_acc;
        rd_vals.push_back(16'h0010);
        push_cmd(1'b0, 1'b1, 3'd4, 16'h0001, 1, 1'b1, 16'h0010, 1'b0, n);
        wait_idle();
        repeat (10) @(posedge clk); #1;
        check("nopoll_acc_count", 32'(n_acc - a0), 1);
`endif

        check("leftover_responses", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
